// File: rtl/linmem_rw_if.sv
// linmem_rw_if: request/response bundle for the linear-memory responder.
//
// Ports (signals):
//   addr         master->slave  AW+1         byte address of window start
//   extra        master->slave  EXTRA        access length - 1 (bytes)
//   lower_bound  master->slave  AW+1         lowest legal byte address
//   upper_bound  master->slave  AW+1         highest legal byte address
//   wr_en        master->slave  1            1 = store, 0 = load
//   wr_data      master->slave  2**EXTRA*8   store data, little-endian
//   data         slave->master  2**EXTRA*8   load data, zero-extended
//   error        slave->master  1            access rejected
//   busy         slave->master  1            store in progress
//   state_dbg    slave->master  1            FSM state (1 = WRITE)
//
// Handshake: there is no valid strobe. Every posedge on which the responder
// is idle (busy low in the previous cycle and not in the cycle busy falls)
// samples the request fields as one access: wr_en=0 is a load answered on
// data/error one cycle later, wr_en=1 is a store. While busy is high the
// request fields are ignored and data/error hold.
interface linmem_rw_if #(
    parameter int AW    = 4,
    parameter int EXTRA = 4
) ();
    localparam int DW = (2 ** EXTRA) * 8;

    logic [AW:0]       addr;
    logic [EXTRA-1:0]  extra;
    logic [AW:0]       lower_bound;
    logic [AW:0]       upper_bound;
    logic              wr_en;
    logic [DW-1:0]     wr_data;
    logic [DW-1:0]     data;
    logic              error;
    logic              busy;
    logic              state_dbg;

    modport master (
        output addr, extra, lower_bound, upper_bound, wr_en, wr_data,
        input  data, error, busy, state_dbg
    );

    modport slave (
        input  addr, extra, lower_bound, upper_bound, wr_en, wr_data,
        output data, error, busy, state_dbg
    );
endinterface

// File: rtl/linmem_rw.sv
// linmem_rw: read/write responder for the core's linear-memory bus.
// Loads return a window of extra+1 bytes one cycle after the request.
// Stores are range-checked, latched, then committed one byte per cycle.
//
// Ports:
//   clk    in   system clock, all logic on posedge
//   reset  in   synchronous, active-high; memory contents are kept
//   bus    linmem_rw_if.slave (see interface file for signal list)
module linmem_rw #(
    parameter int    AW       = 4,
    parameter int    EXTRA    = 4,
    parameter string INITFILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    linmem_rw_if.slave  bus
);
    localparam int NB    = 2 ** EXTRA;
    localparam int DW    = NB * 8;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t            state;
    logic [7:0]        mem [DEPTH];

    logic [AW-1:0]     st_addr;
    logic [EXTRA-1:0]  st_extra;
    logic [DW-1:0]     st_data;
    logic [EXTRA-1:0]  st_idx;

    logic [AW+1:0]     end_addr;
    logic              viol;
    logic [DW-1:0]     rd_data;
    logic [AW-1:0]     wr_ptr;
    logic [7:0]        wr_byte;

    // One extra bit of headroom so addr+extra cannot wrap before the check.
    assign end_addr = (AW+2)'(bus.addr) + (AW+2)'(bus.extra);
    assign viol     = (bus.addr < bus.lower_bound)
                   || (end_addr > (AW+2)'(bus.upper_bound))
                   || (end_addr >= (AW+2)'(DEPTH));

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NB; i++) begin
            if (i <= int'(bus.extra)) begin
                rd_data[8*i +: 8] = mem[AW'(bus.addr + (AW+1)'(i))];
            end
        end
    end

    assign wr_ptr  = st_addr + AW'(st_idx);
    assign wr_byte = st_data[{st_idx, 3'b000} +: 8];

    // Reset blocks the byte in flight so an aborted store leaves the
    // remaining bytes untouched.
    always_ff @(posedge clk) begin
        if (!reset && state == WRITE) begin
            mem[wr_ptr] <= wr_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bus.data  <= '0;
            bus.error <= 1'b0;
            bus.busy  <= 1'b0;
            st_idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.wr_en) begin
                        if (viol) begin
                            bus.error <= 1'b1;
                        end else begin
                            st_addr   <= bus.addr[AW-1:0];
                            st_extra  <= bus.extra;
                            st_data   <= bus.wr_data;
                            st_idx    <= '0;
                            bus.error <= 1'b0;
                            bus.busy  <= 1'b1;
                            state     <= WRITE;
                        end
                    end else begin
                        bus.error <= viol;
                        bus.data  <= viol ? '0 : rd_data;
                    end
                end
                WRITE: begin
                    // The last byte is written on the edge busy falls; the
                    // request seen on that edge is dropped.
                    if (st_idx == st_extra) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        st_idx <= st_idx + EXTRA'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.state_dbg = (state == WRITE);
endmodule

// File: tb/tb_linmem_rw.sv
module tb_linmem_rw;
    localparam int AW    = 4;
    localparam int EXTRA = 4;
    localparam int DW    = (2 ** EXTRA) * 8;
    localparam int DEPTH = 2 ** AW;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    linmem_rw_if #(.AW(AW), .EXTRA(EXTRA)) bus ();

    linmem_rw #(.AW(AW), .EXTRA(EXTRA), .INITFILE("")) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // reference model: byte array plus a count of store bytes still owed
    logic [7:0]    mem_m [DEPTH];
    logic [DW-1:0] m_data;
    logic          m_err;
    int            m_left;
    int            s_addr;
    int            s_idx;
    logic [DW-1:0] s_data;
    int            lo;
    int            hi;

    // scoreboard
    logic [DW+1:0] exp_q [$];
    logic          issued = 1'b0;
    logic          due = 1'b0;
    int            tests = 0;
    int            fails = 0;

    // driver: one request per cycle; the model decides what the DUT owes
    task automatic tick(input bit rst, input bit wr, input int a, input int e,
                        input logic [DW-1:0] wd);
        bit viol;
        @(negedge clk);
        reset           = rst;
        bus.wr_en       = wr;
        bus.addr        = a[AW:0];
        bus.extra       = e[EXTRA-1:0];
        bus.wr_data     = wd;
        bus.lower_bound = lo[AW:0];
        bus.upper_bound = hi[AW:0];
        issued          = 1'b1;
        if (rst) begin
            m_left = 0;
            m_data = '0;
            m_err  = 1'b0;
        end else if (m_left > 0) begin
            mem_m[s_addr + s_idx] = s_data[8*s_idx +: 8];
            s_idx++;
            m_left--;
        end else begin
            viol = (a < lo) || (a + e > hi) || (a + e >= DEPTH);
            if (wr) begin
                if (viol) begin
                    m_err = 1'b1;
                end else begin
                    s_addr = a;
                    s_idx  = 0;
                    s_data = wd;
                    m_left = e + 1;
                    m_err  = 1'b0;
                end
            end else begin
                m_err  = viol;
                m_data = '0;
                if (!viol) begin
                    for (int i = 0; i <= e; i++) m_data[8*i +: 8] = mem_m[a + i];
                end
            end
        end
        exp_q.push_back({(m_left > 0), m_err, m_data});
    endtask

    task automatic do_load(input int a, input int e);
        tick(1'b0, 1'b0, a, e, '0);
    endtask

    // issue a store, then keep loading addr 0 until the store drains;
    // those loads (including the one on the falling edge) must be ignored
    task automatic do_store(input int a, input int e, input logic [DW-1:0] d);
        tick(1'b0, 1'b1, a, e, d);
        for (int n = 0; n < 20 && m_left > 0; n++) tick(1'b0, 1'b0, 0, e, '0);
    endtask

    // monitor: every sampled cycle owes one response
    always @(posedge clk) due <= issued;

    always @(negedge clk) begin
        logic [DW+1:0] exp;
        if (due) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL queue_underrun: response with no expectation at %0t", $time);
            end else begin
                exp = exp_q.pop_front();
                if (bus.busy !== exp[DW+1]) begin
                    fails++;
                    $display("FAIL busy @%0t: got %b want %b", $time, bus.busy, exp[DW+1]);
                end
                tests++;
                if (bus.error !== exp[DW]) begin
                    fails++;
                    $display("FAIL error @%0t: got %b want %b", $time, bus.error, exp[DW]);
                end
                tests++;
                if (bus.data !== exp[DW-1:0]) begin
                    fails++;
                    $display("FAIL data @%0t: got %h want %h", $time, bus.data, exp[DW-1:0]);
                end
            end
        end
    end

    initial begin
        bus.wr_en = 1'b0;
        bus.addr = '0;
        bus.extra = '0;
        bus.wr_data = '0;
        bus.lower_bound = '0;
        bus.upper_bound = '0;
        m_data = '0;
        m_err = 1'b0;
        m_left = 0;
        s_addr = 0;
        s_idx = 0;
        s_data = '0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
        lo = 0;
        hi = DEPTH - 1;

        // reset state
        tick(1'b1, 1'b0, 0, 0, '0);
        tick(1'b1, 1'b0, 0, 0, '0);

        // fill every byte so later loads see known contents
        do_store(0, 7, 64'hA7A6A5A4A3A2A1A0);
        do_store(8, 7, 64'hAFAEADACABAAA9A8);

        // i32 42 at address 3
        do_store(3, 3, 32'h0000002A);
        do_load(3, 3);

        // store then load back
        do_store(8, 3, 32'hDEADBEEF);
        do_load(8, 3);

        // bounds window 4..11
        lo = 4;
        hi = 11;
        do_load(2, 0);
        tick(1'b0, 1'b1, 10, 3, 32'h01020304);
        do_load(4, 7);
        lo = 0;
        hi = DEPTH - 1;
        do_load(8, 7);

        // end of memory
        do_load(14, 3);
        do_load(15, 0);
        do_load(16, 0);

        // reset three bytes into an 8-byte store
        tick(1'b0, 1'b1, 0, 7, 64'h1122334455667788);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 0, 7, '0);
        tick(1'b1, 1'b0, 0, 0, '0);
        do_load(0, 7);

        // loads during a store are ignored; reissued load sees new bytes
        do_store(0, 3, 32'hCAFEF00D);
        do_load(0, 7);

        // full-width and single-byte accesses
        do_store(0, 15, {$urandom(), $urandom(), $urandom(), $urandom()});
        do_load(0, 15);
        do_store(5, 0, 8'h5A);
        do_load(4, 2);

        // randomized traffic, including resets during stores
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 29) == 0) begin
                lo = $urandom_range(0, 6);
                hi = $urandom_range(8, 15);
            end else if ($urandom_range(0, 29) == 0) begin
                lo = 0;
                hi = DEPTH - 1;
            end
            tick(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
                 $urandom_range(0, 20),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 7),
                 {$urandom(), $urandom(), $urandom(), $urandom()});
        end

        @(negedge clk);
        issued = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
